keypoint_nms: RTL and testbench

//  3x3 non-maximum suppression stage directly downstream of the 3x3 score sliding window.

---
 rtl/tarsier_pkg.sv | 15 +
 rtl/keypoint_fifo.sv | 56 +++++
 rtl/keypoint_nms.sv | 129 ++++++++++++
 tb/tb_keypoint_nms.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tarsier_pkg.sv
// Shared types and window geometry for the keypoint NMS stage.
package tarsier_pkg;

  localparam int unsigned KP_DATA_BITS  = 8;
  localparam int unsigned KP_COORD_BITS = 11;
  localparam int unsigned WIN_SIZE      = 3;
  localparam int unsigned WIN_CENTRE    = 1;

  typedef struct packed {
    logic [KP_COORD_BITS-1:0] x;
    logic [KP_COORD_BITS-1:0] y;
    logic [KP_DATA_BITS-1:0]  score;
  } keypoint_t;

endpackage

// File: rtl/keypoint_fifo.sv
// Synchronous keypoint FIFO; the extra pointer MSB tells full from empty.
module keypoint_fifo
  import tarsier_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  keypoint_t din,
  output keypoint_t dout,
  output logic      full,
  output logic      empty
);

  localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  keypoint_t        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Status flags, guarded push/pop and pointer advance.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
               (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[IDX_W-1:0]] <= din;
  end

  assign dout = mem_q[rd_ptr_q[IDX_W-1:0]];

endmodule

// File: rtl/keypoint_nms.sv
// 3x3 non-maximum suppression: raster tracking, keep test, keypoint queue.
module keypoint_nms
  import tarsier_pkg::*;
#(
  parameter int unsigned DATA_BITS  = KP_DATA_BITS,
  parameter int unsigned COORD_BITS = KP_COORD_BITS,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned OVF_BITS   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [COORD_BITS-1:0] r_row_length,
  input  logic [COORD_BITS-1:0] r_num_rows,
  input  logic [DATA_BITS-1:0]  r_threshold,
  input  logic                  in_valid,
  input  logic [WIN_SIZE-1:0][WIN_SIZE-1:0][DATA_BITS-1:0] in_window,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COORD_BITS-1:0] out_x,
  output logic [COORD_BITS-1:0] out_y,
  output logic [DATA_BITS-1:0]  out_score,
  output logic                  out_frame_done,
  output logic [OVF_BITS-1:0]   overflow_count
);

  localparam logic [COORD_BITS-1:0] ONE = COORD_BITS'(1);
  localparam logic [COORD_BITS-1:0] TWO = COORD_BITS'(2);

  logic [COORD_BITS-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_BITS-1:0] px_q, px_d, py_q, py_d;
  logic                  eval_q, eval_d;
  logic                  fd_q, fd_d;
  logic                  push_q, push_d;
  keypoint_t             kp_q, kp_d;
  logic [OVF_BITS-1:0]   ovf_q, ovf_d;

  logic [DATA_BITS-1:0]  centre;
  logic                  keep;
  logic                  pop, fifo_push, fifo_full, fifo_empty;
  keypoint_t             head;

  // Raster counters and the eval pipeline stage for the pixel being accepted.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    px_d   = px_q;
    py_d   = py_q;
    eval_d = in_valid;
    fd_d   = in_valid && (x_q == r_row_length - ONE) && (y_q == r_num_rows - ONE);
    if (in_valid) begin
      px_d = x_q;
      py_d = y_q;
      if (x_q == r_row_length - ONE) begin
        x_d = '0;
        y_d = (y_q == r_num_rows - ONE) ? '0 : y_q + ONE;
      end else begin
        x_d = x_q + ONE;
      end
    end
  end

  // Keep test: earlier neighbours compared strictly, later ones with >=.
  always_comb begin
    centre = in_window[WIN_CENTRE][WIN_CENTRE];
    keep   = (centre >  r_threshold)
          && (centre >  in_window[0][0]) && (centre >  in_window[0][1])
          && (centre >  in_window[0][2]) && (centre >  in_window[1][0])
          && (centre >= in_window[1][2]) && (centre >= in_window[2][0])
          && (centre >= in_window[2][1]) && (centre >= in_window[2][2]);
    push_d     = eval_q && (px_q >= TWO) && (py_q >= TWO) && keep;
    kp_d.x     = KP_COORD_BITS'(px_q - ONE);
    kp_d.y     = KP_COORD_BITS'(py_q - ONE);
    kp_d.score = KP_DATA_BITS'(centre);
  end

  // Queue admission: a full FIFO still accepts when the head leaves this cycle.
  always_comb begin
    pop       = !fifo_empty && out_ready;
    fifo_push = push_q && (!fifo_full || pop);
    ovf_d     = ovf_q;
    if (push_q && !fifo_push && (ovf_q != {OVF_BITS{1'b1}})) ovf_d = ovf_q + OVF_BITS'(1);
  end

  // Pipeline, counter and overflow registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q    <= '0;
      y_q    <= '0;
      px_q   <= '0;
      py_q   <= '0;
      eval_q <= 1'b0;
      fd_q   <= 1'b0;
      push_q <= 1'b0;
      kp_q   <= '0;
      ovf_q  <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      px_q   <= px_d;
      py_q   <= py_d;
      eval_q <= eval_d;
      fd_q   <= fd_d;
      push_q <= push_d;
      kp_q   <= kp_d;
      ovf_q  <= ovf_d;
    end
  end

  keypoint_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (fifo_push),
    .pop   (pop),
    .din   (kp_q),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid      = !fifo_empty;
  assign out_x          = COORD_BITS'(head.x);
  assign out_y          = COORD_BITS'(head.y);
  assign out_score      = DATA_BITS'(head.score);
  assign out_frame_done = fd_q;
  assign overflow_count = ovf_q;

endmodule

// File: tb/tb_keypoint_nms.sv
// Scoreboard bench for keypoint_nms: image-level reference, queue-based checking.
module tb_keypoint_nms;

  localparam int DB = 8;
  localparam int CB = 11;
  localparam int DEPTH = 4;
  localparam int OB = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [CB-1:0] r_row_length, r_num_rows;
  logic [DB-1:0] r_threshold;
  logic in_valid, out_ready, out_valid, out_frame_done;
  logic [2:0][2:0][DB-1:0] in_window;
  logic [CB-1:0] out_x, out_y;
  logic [DB-1:0] out_score;
  logic [OB-1:0] overflow_count;

  always #5 clk = ~clk;

  keypoint_nms #(
    .DATA_BITS(DB), .COORD_BITS(CB), .FIFO_DEPTH(DEPTH), .OVF_BITS(OB)
  ) dut (
    .clk(clk), .reset(reset),
    .r_row_length(r_row_length), .r_num_rows(r_num_rows), .r_threshold(r_threshold),
    .in_valid(in_valid), .in_window(in_window),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_score(out_score),
    .out_frame_done(out_frame_done), .overflow_count(overflow_count)
  );

  typedef struct {int x; int y; int s;} kp_s;

  kp_s sb[$];
  int  img [16][16];
  bit  kmap [16][16];
  int  L, N, TH, ready_mode;
  int  bx, by, acc_x, acc_y, occ, m_ovf, exp_ovf;
  bit  acc_v, st_v, exp_valid, exp_fd, chk_en;
  kp_s st_kp, last_pop;
  int  n_cmp, n_err, n_pop, n_fd;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference keep map straight from the neighbourhood rule on the image.
  function automatic void compute_kmap();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) kmap[y][x] = 1'b0;
    for (int cy = 1; cy <= N - 2; cy++)
      for (int cx = 1; cx <= L - 2; cx++) begin
        bit k;
        k = img[cy][cx] > TH;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (!(dy == 0 && dx == 0)) begin
              if (dy < 0 || (dy == 0 && dx < 0)) k = k && (img[cy][cx] >  img[cy+dy][cx+dx]);
              else                               k = k && (img[cy][cx] >= img[cy+dy][cx+dx]);
            end
        kmap[cy][cx] = k;
      end
  endfunction

  function automatic void clear_img();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) img[y][x] = 0;
  endfunction

  task automatic set_frame(input int l, input int n, input int th);
    L = l; N = n; TH = th;
    r_row_length = CB'(l);
    r_num_rows   = CB'(n);
    r_threshold  = DB'(th);
  endtask

  // One clock of stimulus plus the model step for the coming edge.
  task automatic cycle(input bit v);
    bit  ev, ev_keep, pop;
    int  ex, ey;
    @(negedge clk);
    ev = acc_v; ex = acc_x; ey = acc_y;
    if (ev) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          if (ex >= 2 && ey >= 2) in_window[r][c] = DB'(img[ey-2+r][ex-2+c]);
          else in_window[r][c] = DB'($urandom_range(0, 1) != 0 ? 200 : $urandom_range(0, 255));
    end
    ev_keep = ev && ex >= 2 && ey >= 2 && kmap[ey-1][ex-1];
    exp_fd  = ev && ex == L - 1 && ey == N - 1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      2:       out_ready = ($urandom_range(0, 1) != 0);
      default: out_ready = st_v;
    endcase
    exp_valid = occ > 0;
    exp_ovf   = m_ovf;
    pop = (occ > 0) && out_ready;
    if (st_v) begin
      if (occ < DEPTH || pop) begin sb.push_back(st_kp); occ++; end
      else if (m_ovf < 65535) m_ovf++;
    end
    if (pop) occ--;
    st_v = ev_keep;
    if (ev_keep) st_kp = '{ex - 1, ey - 1, img[ey-1][ex-1]};
    in_valid = v;
    acc_v = v; acc_x = bx; acc_y = by;
    if (v) begin
      if (bx == L - 1) begin bx = 0; by = (by == N - 1) ? 0 : by + 1; end
      else bx++;
    end
    chk_en = 1'b1;
  endtask

  task automatic run_frame(input int idle_pct, input int limit);
    int total;
    total = L * N;
    if (limit > 0 && limit < total) total = limit;
    for (int p = 0; p < total; p++) begin
      while ($urandom_range(0, 99) < idle_pct) cycle(1'b0);
      cycle(1'b1);
    end
    repeat (4) cycle(1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    chk_en = 1'b0; reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sb.delete(); occ = 0; m_ovf = 0; st_v = 1'b0; acc_v = 1'b0; bx = 0; by = 0;
    #1;
    check("valid_in_reset", int'(out_valid), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic six_peaks();
    clear_img();
    img[2][2] = 30; img[2][5] = 40; img[4][2] = 50;
    img[4][5] = 60; img[6][2] = 70; img[6][5] = 80;
    compute_kmap();
  endtask

  // Monitor: compares status every cycle and pops the scoreboard on handshake.
  initial begin : monitor
    kp_s e;
    forever begin
      @(negedge clk);
      #2;
      if (chk_en && reset) begin
        check("out_valid", int'(out_valid), int'(exp_valid));
        check("frame_done", int'(out_frame_done), int'(exp_fd));
        check("overflow_count", int'(overflow_count), exp_ovf);
        if (out_frame_done) n_fd++;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_pop: got (%0d,%0d,%0d) expected none", out_x, out_y, out_score);
          end else begin
            e = sb.pop_front();
            check("out_x", int'(out_x), e.x);
            check("out_y", int'(out_y), e.y);
            check("out_score", int'(out_score), e.s);
          end
          n_pop++;
          last_pop = '{int'(out_x), int'(out_y), int'(out_score)};
        end
      end
    end
  end

  initial begin : stimulus
    int p0, f0;
    n_cmp = 0; n_err = 0; n_pop = 0; n_fd = 0; chk_en = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_window = '0;
    occ = 0; m_ovf = 0; st_v = 1'b0; acc_v = 1'b0; bx = 0; by = 0;
    last_pop = '{-1, -1, -1};
    set_frame(8, 8, 10);
    clear_img(); compute_kmap();
    do_reset();
    #1;
    check("rst_overflow", int'(overflow_count), 0);
    check("rst_frame_done", int'(out_frame_done), 0);

    // Single isolated peak.
    clear_img(); img[3][4] = 50; compute_kmap(); ready_mode = 1;
    p0 = n_pop; f0 = n_fd;
    run_frame(20, 0); #3;
    check("t1_count", n_pop - p0, 1);
    check("t1_frame_done_pulses", n_fd - f0, 1);
    check("t1_x", last_pop.x, 4);
    check("t1_y", last_pop.y, 3);
    check("t1_score", last_pop.s, 50);

    // 2x2 plateau collapses to a single keypoint.
    clear_img(); img[3][3] = 50; img[3][4] = 50; img[4][3] = 50; img[4][4] = 50;
    compute_kmap();
    p0 = n_pop;
    run_frame(0, 0); #3;
    check("t2_count", n_pop - p0, 1);
    check("t2_score", last_pop.s, 50);

    // Border and early-row peaks never report.
    clear_img(); img[3][0] = 200; img[5][7] = 200; img[0][4] = 200; img[1][3] = 200;
    compute_kmap();
    p0 = n_pop;
    run_frame(10, 0); #3;
    check("t3_count", n_pop - p0, 0);

    // Overflow with a stalled consumer, then drain.
    do_reset();
    six_peaks(); ready_mode = 0; p0 = n_pop;
    run_frame(0, 0); #3;
    check("t4_overflow", int'(overflow_count), 2);
    check("t4_valid_held", int'(out_valid), 1);
    check("t4_no_pops", n_pop - p0, 0);
    ready_mode = 1;
    repeat (8) cycle(1'b0);
    #3;
    check("t4_drain_pops", n_pop - p0, 4);
    check("t4_last_x", last_pop.x, 5);
    check("t4_last_y", last_pop.y, 4);
    check("t4_last_score", last_pop.s, 60);

    // Full FIFO with a simultaneous pop still takes the push.
    ready_mode = 0;
    run_frame(0, 0); #3;
    check("t5_prefill_overflow", int'(overflow_count), 4);
    ready_mode = 3; p0 = n_pop;
    run_frame(0, 0); #3;
    check("t5_overflow_unchanged", int'(overflow_count), 4);
    check("t5_pops", n_pop - p0, 6);
    check("t5_still_full_valid", int'(out_valid), 1);
    ready_mode = 1;
    repeat (8) cycle(1'b0);

    // Reset mid-frame with three queued, then a clean frame.
    ready_mode = 0;
    run_frame(0, 44); #3;
    check("t6_queued_valid", int'(out_valid), 1);
    do_reset();
    #1;
    check("t6_overflow_cleared", int'(overflow_count), 0);
    clear_img(); img[3][4] = 50; compute_kmap(); ready_mode = 1;
    p0 = n_pop;
    run_frame(0, 0); #3;
    check("t6_count", n_pop - p0, 1);
    check("t6_x", last_pop.x, 4);
    check("t6_y", last_pop.y, 3);

    // Randomized frames with a random consumer.
    ready_mode = 2;
    for (int f = 0; f < 6; f++) begin
      set_frame($urandom_range(3, 10), $urandom_range(3, 10), 3);
      clear_img();
      for (int y = 0; y < N; y++)
        for (int x = 0; x < L; x++) img[y][x] = $urandom_range(0, 7);
      compute_kmap();
      run_frame(25, 0);
    end
    ready_mode = 1;
    repeat (8) cycle(1'b0);
    #3;
    check("end_scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
